// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and burst FSM states.
package usr_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    HOLD  = 3'b000,
    SHR   = 3'b001,
    SHL   = 3'b010,
    ROR   = 3'b011,
    ROL   = 3'b100,
    ASR   = 3'b101,
    LOAD  = 3'b110,
    BURST = 3'b111
  } usr_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } burst_state_e;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst engine: accepts a shift count and strobes shift_en once per cycle
// until the count is exhausted, then pulses done for one cycle.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  burst_state_e     state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          // A zero-length burst completes immediately without entering RUN.
          if (cnt == '0) begin
            done_nxt = 1'b1;
          end else begin
            count_nxt = cnt;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        count_nxt = count - 1'b1;
        if (count == CNT_W'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN);
    shift_en = (state == RUN);
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register with shifts, rotates, arithmetic shift,
// parallel load and a counted right-shift burst driven by usr_burst_ctrl.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  PI,
  input  logic              sin_r,
  input  logic              sin_l,
  input  logic [CNT_W-1:0]  cnt,
  output logic [WIDTH-1:0]  PO,
  output logic              sout_r,
  output logic              sout_l,
  output logic              busy,
  output logic              done
);

  usr_mode_e        op;
  logic             start;
  logic             shift_en;
  logic [WIDTH-1:0] po_nxt;

  assign op     = usr_mode_e'(mode);
  assign start  = en && !busy && (op == BURST);
  assign sout_r = PO[0];
  assign sout_l = PO[WIDTH-1];

  usr_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cnt      (cnt),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done)
  );

  // An active burst owns the register; en/mode only matter when idle.
  always_comb begin
    po_nxt = PO;
    if (shift_en) begin
      po_nxt = {sin_r, PO[WIDTH-1:1]};
    end else if (en && !busy) begin
      case (op)
        SHR:     po_nxt = {sin_r, PO[WIDTH-1:1]};
        SHL:     po_nxt = {PO[WIDTH-2:0], sin_l};
        ROR:     po_nxt = {PO[0], PO[WIDTH-1:1]};
        ROL:     po_nxt = {PO[WIDTH-2:0], PO[WIDTH-1]};
        ASR:     po_nxt = {PO[WIDTH-1], PO[WIDTH-1:1]};
        LOAD:    po_nxt = PI;
        default: po_nxt = PO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) PO <= '0;
    else     PO <= po_nxt;
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench: stimulus pushes the hand-computed state expected after each
// edge; a monitor pops and compares it against the outputs on the falling edge.
module tb_univ_shift_reg;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] PI = '0;
  logic       sin_r = 1'b0;
  logic       sin_l = 1'b0;
  logic [3:0] cnt = '0;
  logic [7:0] PO;
  logic       sout_r, sout_l, busy, done;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .PI(PI),
    .sin_r(sin_r), .sin_l(sin_l), .cnt(cnt),
    .PO(PO), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] po;
    logic       b;
    logic       d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  int   done_at[$];
  logic [11:0] act, req;

  // Monitor: every cycle the register presents a state, compare it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (done === 1'b1) done_at.push_back(cyc_n);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {PO, busy, done, sout_r, sout_l};
        req = {e.po, e.b, e.d, e.po[0], e.po[7]};
        checks++;
        if (act !== req) begin
          errors++;
          $display("FAIL %s: got PO=%h busy=%b done=%b sr=%b sl=%b, want PO=%h busy=%b done=%b sr=%b sl=%b",
                   e.nm, PO, busy, done, sout_r, sout_l, e.po, e.b, e.d, e.po[0], e.po[7]);
        end
      end
    end
  end

  task automatic tick(input string nm, input logic [7:0] po, input logic b, input logic d);
    exp_t e;
    @(posedge clk);
    e.nm = nm; e.po = po; e.b = b; e.d = d;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic op(input string nm, input usr_mode_e m, input logic [7:0] po);
    en = 1'b1; mode = m;
    tick(nm, po, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [7:0] v);
    en = 1'b1; mode = LOAD; PI = v;
    tick("load", v, 1'b0, 1'b0);
  endtask

  logic [7:0] b10 [10] = '{8'hD2, 8'hE9, 8'hF4, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] b5  [5]  = '{8'h1E, 8'h0F, 8'h07, 8'h03, 8'h01};

  initial begin
    rst = 1'b1;
    tick("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    ld(8'hA5);
    sin_r = 1'b1; op("shr", SHR, 8'hD2);
    ld(8'hA5); sin_l = 1'b0; op("shl", SHL, 8'h4A);
    ld(8'hA5); op("ror", ROR, 8'hD2);
    ld(8'hA5); op("rol", ROL, 8'h4B);
    ld(8'hA5); op("asr_neg", ASR, 8'hD2);
    ld(8'h25); op("asr_pos", ASR, 8'h12);
    en = 1'b0; mode = SHR; tick("en0_hold", 8'h12, 1'b0, 1'b0);
    en = 1'b1; op("hold", HOLD, 8'h12);

    // Burst of 3 from A5, zero fill.
    ld(8'hA5);
    sin_r = 1'b0; cnt = 4'd3; en = 1'b1; mode = BURST;
    tick("b3_acc", 8'hA5, 1'b1, 1'b0);
    en = 1'b0;
    tick("b3_s1", 8'h52, 1'b1, 1'b0);
    tick("b3_s2", 8'h29, 1'b1, 1'b0);
    tick("b3_s3", 8'h14, 1'b0, 1'b1);
    tick("b3_idle", 8'h14, 1'b0, 1'b0);

    // Zero-length burst.
    en = 1'b1; mode = BURST; cnt = 4'd0;
    tick("b0_done", 8'h14, 1'b0, 1'b1);
    mode = HOLD;
    tick("b0_idle", 8'h14, 1'b0, 1'b0);

    // Burst longer than the register, one-filled.
    ld(8'hA5);
    sin_r = 1'b1; cnt = 4'd10; mode = BURST;
    tick("b10_acc", 8'hA5, 1'b1, 1'b0);
    mode = HOLD;
    for (int k = 0; k < 10; k++)
      tick($sformatf("b10_s%0d", k + 1), b10[k], (k != 9), (k == 9));

    // Disturbances during a burst are ignored.
    ld(8'h3C);
    sin_r = 1'b0; cnt = 4'd5; mode = BURST;
    tick("b5_acc", 8'h3C, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      en = k[0]; mode = (k < 2) ? LOAD : SHL; PI = 8'hFF; cnt = 4'hF; sin_l = 1'b1;
      tick($sformatf("b5_s%0d", k + 1), b5[k], (k != 4), (k == 4));
    end
    en = 1'b1; mode = HOLD;
    tick("b5_idle", 8'h01, 1'b0, 1'b0);

    // Reset in the third busy cycle aborts without done.
    ld(8'hA5);
    cnt = 4'd5; mode = BURST;
    tick("abort_acc", 8'hA5, 1'b1, 1'b0);
    tick("abort_s1", 8'h52, 1'b1, 1'b0);
    tick("abort_s2", 8'h29, 1'b1, 1'b0);
    rst = 1'b1;
    tick("abort_rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0; mode = HOLD;
    tick("abort_post1", 8'h00, 1'b0, 1'b0);
    tick("abort_post2", 8'h00, 1'b0, 1'b0);

    // Back-to-back bursts, second accepted in the done cycle.
    ld(8'h81);
    sin_r = 1'b1; cnt = 4'd2; mode = BURST;
    tick("bb1_acc", 8'h81, 1'b1, 1'b0);
    mode = HOLD;
    tick("bb1_s1", 8'hC0, 1'b1, 1'b0);
    tick("bb1_s2", 8'hE0, 1'b0, 1'b1);
    mode = BURST;
    tick("bb2_acc", 8'hE0, 1'b1, 1'b0);
    mode = HOLD;
    tick("bb2_s1", 8'hF0, 1'b1, 1'b0);
    tick("bb2_s2", 8'hF8, 1'b0, 1'b1);
    tick("bb_idle", 8'hF8, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    checks++;
    if (done_at.size() != 6) begin
      errors++;
      $display("FAIL done_count: got %0d, want 6", done_at.size());
    end else begin
      checks++;
      if (done_at[5] - done_at[4] != 3) begin
        errors++;
        $display("FAIL done_spacing: got %0d, want 3", done_at[5] - done_at[4]);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the team's 8-bit, 2-bit-mode master-slave shift registers.
- Register of WIDTH bits with eight operating modes: hold, logical shifts, rotates, arithmetic shift, parallel load, and a counted burst shift-out.
- Serial taps exist at both ends.
- Sits between parallel datapath logic and serial links (serialiser/deserialiser front end). The burst engine frees the controller from counting shifts itself.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of the burst-length input; max burst = 2**CNT_W-1 shifts.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  operation enable; when 0 and not busy, register holds.
- mode  in  3  operation select (encodings below).
- PI  in  WIDTH  parallel load data.
- sin_r  in  1  serial input entering at MSB on right shift/burst.
- sin_l  in  1  serial input entering at LSB on left shift.
- cnt  in  CNT_W  burst length, sampled on burst accept.
- PO  out  WIDTH  register contents.
- sout_r  out  1  equals PO[0] (combinational from register).
- sout_l  out  1  equals PO[WIDTH-1].
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (rst=1 at an edge): PO=0, busy=0, done=0, internal counter=0. Reset has priority over everything, including mid-burst. An aborted burst produces no done pulse.
- Mode encodings, applied at the edge when en=1 and busy=0:
  - 000 HOLD.
  - 001 SHR: {sin_r, PO[W-1:1]}.
  - 010 SHL: {PO[W-2:0], sin_l}.
  - 011 ROR: {PO[0], PO[W-1:1]}.
  - 100 ROL: {PO[W-2:0], PO[W-1]}.
  - 101 ASR: {PO[W-1], PO[W-1:1]}.
  - 110 LOAD: PO<=PI.
  - 111 BURST: accept.
- Latency: one edge for all non-burst modes. PO reflects the new value in the cycle after the edge.
- Burst accept at edge T (en=1, busy=0, mode=111):
  - cnt=0: no shift; busy stays 0; done=1 for the cycle after T.
  - cnt=N>0: counter<=N, busy<=1, PO unchanged at T.
- While busy:
  - Every edge performs SHR with current sin_r and decrements the counter.
  - en and mode are ignored. PI and cnt changes have no effect.
- Completion: the N-th shift occurs at edge T+N. At that edge busy<=0 and done<=1. done stays high exactly one cycle.
  - A new command may be accepted in the cycle done is high, i.e. at edge T+N+1.
  - Back-to-back bursts are legal: a burst accepted at T+N+1 asserts busy again after that edge.
- N>WIDTH is legal. Bits beyond WIDTH are filled entirely from sin_r.
- done is 0 in all cycles other than the completion pulse. busy=1 exactly for cycles T+1..T+N.
- en=0 with busy=0: hold regardless of mode.

Decomposition:
- Package usr_pkg:
  - Enum usr_mode_e (3-bit): HOLD, SHR, SHL, ROR, ROL, ASR, LOAD, BURST.
  - Helper constant MODE_W=3.
- Sub-module usr_burst_ctrl (CNT_W): accept/count/busy/done FSM.
  - States: IDLE, RUN.
  - Outputs a shift_en strobe to the datapath.
- The datapath mux stays in the top module.

Test Plan (WIDTH=8, CNT_W=4):
- Reset then LOAD: rst=1 one edge, then en=1, mode=LOAD, PI=8'hA5 -> PO=00 after reset, PO=A5 next cycle, busy=0, done=0.
- Shift/rotate sweep, each from PO=A5:
  - SHR with sin_r=1 -> D2.
  - SHL with sin_l=0 -> 4A.
  - ROR -> D2.
  - ROL -> 4B.
  - ASR -> D2.
  - PO=25 with ASR -> 12.
- Burst: PO=A5, BURST with cnt=3, sin_r=0 -> busy high 3 cycles; PO: A5,52,29,14; done pulses in the cycle PO=14; sout_r sequence 1,0,1,0.
- Burst edge cases:
  - cnt=0 -> done pulses next cycle, PO unchanged, busy never 1.
  - cnt=10 with sin_r=1 from A5 -> PO=FF at completion.
- Mid-burst disturbances: during cnt=5 burst, toggle mode/en/PI -> ignored. rst asserted at 3rd busy cycle -> PO=00, busy=0, no done pulse.
- Back-to-back: BURST cnt=2 accepted again in done cycle -> second busy window starts next cycle; total done pulses=2, spaced 3 cycles apart.
